alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/ALU_FNS.sv | 35 +++
 rtl/alu_seq_muldiv.sv | 116 +++++++++++
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ALU_FNS.sv
// Shared operation and FSM state types for the sequential ALU (alu_seq).
package ALU_FNS;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(alu_op_t op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 multiplier / restoring divider: WIDTH iteration cycles after start,
// then done stays high (with a valid result) for one cycle.
module alu_seq_muldiv
  import ALU_FNS::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  alu_op_t              op_q;
  logic                 running;
  logic [SHAMT_W:0]     cnt;
  logic [WIDTH-1:0]     a_q, mag_a, mag_b, rem, quo;
  logic [2*WIDTH:0]     acc;
  logic                 neg_res, neg_rem, b_zero;

  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_upper, r_sh, diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 is_mul;

  // Operands are reduced to magnitudes; the sign is reapplied on the way out.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    abs_a    = a_neg ? (~a + 1'b1) : a;
    abs_b    = b_neg ? (~b + 1'b1) : b;
  end

  always_comb begin
    is_mul    = (op_q <= OP_MULHU);
    mul_upper = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mag_a}) : acc[2*WIDTH:WIDTH];
    r_sh      = {rem, quo[WIDTH-1]};
    diff      = r_sh - {1'b0, mag_b};
    prod_fix  = neg_res ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
    quo_fix   = neg_res ? (~quo + 1'b1) : quo;
    rem_fix   = neg_rem ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_ADD;
      running <= 1'b0;
      cnt     <= '0;
      a_q     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
    end else if (flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      op_q    <= op;
      running <= 1'b1;
      cnt     <= '0;
      a_q     <= a;
      mag_a   <= abs_a;
      mag_b   <= abs_b;
      acc     <= {{(WIDTH+1){1'b0}}, abs_b};
      rem     <= '0;
      quo     <= abs_a;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      b_zero  <= (b == '0);
    end else if (running) begin
      if (cnt == (SHAMT_W+1)'(WIDTH)) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (is_mul) begin
          acc <= {mul_upper, acc[WIDTH-1:0]} >> 1;
        end else if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= r_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign done = running && (cnt == (SHAMT_W+1)'(WIDTH));

  // Divide by zero bypasses the sign fix-up; signed overflow falls out of the magnitude path.
  always_comb begin
    case (op_q)
      OP_MUL:                        result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               result = b_zero ? '1 : quo_fix;
      OP_REM, OP_REMU:               result = b_zero ? a_q : rem_fix;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready in/out handshakes. Define ALU_SEQ_MULDIV_EN to build the
// iterative multiply/divide path; otherwise those ops complete in one cycle flagged illegal.
module alu_seq
  import ALU_FNS::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic             busy
);

  // Handshake: an op transfers when in_valid && in_ready at a rising edge; a result retires
  // when out_valid && out_ready; out_result/out_illegal are stable while out_valid && !out_ready.
  alu_state_t         state;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_illegal;
  logic               go_multi;
  logic               md_done;
  logic [WIDTH-1:0]   md_result;

  assign in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign shamt     = in_b[SHAMT_W-1:0];

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (in_op)
      OP_ADD:  sc_result = in_a + in_b;
      OP_SUB:  sc_result = in_a - in_b;
      OP_AND:  sc_result = in_a & in_b;
      OP_OR:   sc_result = in_a | in_b;
      OP_XOR:  sc_result = in_a ^ in_b;
      OP_SLL:  sc_result = in_a << shamt;
      OP_SRL:  sc_result = in_a >> shamt;
      OP_SRA:  sc_result = $unsigned($signed(in_a) >>> shamt);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic md_start;

  assign go_multi = is_muldiv(in_op);
  assign md_start = accept && go_multi;
  assign busy     = (state == ST_BUSY);

  alu_seq_muldiv #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign go_multi  = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (accept) begin
      if (go_multi) begin
        state <= ST_BUSY;
      end else begin
        state       <= ST_DONE;
        out_result  <= sc_result;
        out_illegal <= sc_illegal;
      end
    end else begin
      case (state)
        ST_BUSY: if (md_done) begin
          state       <= ST_DONE;
          out_result  <= md_result;
          out_illegal <= 1'b0;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq; expectations follow ALU_SEQ_MULDIV_EN when it is defined.
module tb_alu_seq;
  import ALU_FNS::*;

  localparam int WIDTH = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, flush, out_valid, out_ready, out_illegal, busy;
  alu_op_t          in_op;
  logic [WIDTH-1:0] in_a, in_b, out_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH:0] exp_q[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [WIDTH:0] model(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] p;
    logic [4:0]         sh;
    logic               ill;
    r   = '0;
    p   = '0;
    ill = 1'b0;
    sh  = b[4:0];
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = a << sh;
      5'd6: r = a >> sh;
      5'd7: r = (a >> sh) | (a[WIDTH-1] ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}});
      5'd8: r = (a[WIDTH-1] != b[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, a[WIDTH-1]}
                                           : {{(WIDTH-1){1'b0}}, (a < b)};
      5'd9: r = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_MULDIV_EN
      5'd10: begin p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}; r = p[WIDTH-1:0]; end
      5'd11: begin p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}; r = p[2*WIDTH-1:WIDTH]; end
      5'd12: begin p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{1'b0}}, b}; r = p[2*WIDTH-1:WIDTH]; end
      5'd13: begin p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}; r = p[2*WIDTH-1:WIDTH]; end
      5'd14: begin
        if (b == '0) r = '1;
        else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) r = a;
        else r = $signed(a) / $signed(b);
      end
      5'd15: begin
        if (b == '0) r = '1;
        else r = a / b;
      end
      5'd16: begin
        if (b == '0) r = a;
        else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) r = '0;
        else r = $signed(a) % $signed(b);
      end
      5'd17: begin
        if (b == '0) r = a;
        else r = a % b;
      end
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (!rst && out_valid && out_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL result_unexpected: got ill=%b res=%h, required no output", out_illegal, out_result);
      end else begin
        e = exp_q.pop_front();
        if ({out_illegal, out_result} !== e)
          begin
            errors = errors + 1;
            $display("FAIL result_value: got ill=%b res=%h, required ill=%b res=%h",
                     out_illegal, out_result, e[WIDTH], e[WIDTH-1:0]);
          end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] exp, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_op    = alu_op_t'(op);
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    checks = checks + 1;
    if (!in_ready) begin
      errors = errors + 1;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks = checks + 1;
    if (seen !== 0) begin
      errors = errors + 1;
      $display("FAIL %s: out_valid cycles=%0d, required 0", name, seen);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = OP_ADD; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_result !== '0) begin errors++; $display("FAIL reset_out_result: got %h, required 0", out_result); end
    if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal: got %b, required 0", out_illegal); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    #1;
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    tick();
  endtask

  task automatic test_single_cycle();
    logic [4:0]       t_op[11];
    logic [WIDTH-1:0] t_a[11], t_b[11], t_r[11];
    t_op = '{5'd0, 5'd1, 5'd8, 5'd9, 5'd7, 5'd6, 5'd5, 5'd2, 5'd3, 5'd4, 5'd7};
    t_a  = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
             32'h00000001, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h7FFFFFFF};
    t_b  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h21, 32'h3F, 32'h25, 32'hFF00FF00, 32'h0F0F0000,
             32'h0F0F0F0F, 32'h4};
    t_r  = '{32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hC0000000, 32'h1, 32'h20,
             32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'h07FFFFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(t_op[i], t_a[i], t_b[i], {1'b0, t_r[i]}, 1'b1);
      checks = checks + 1;
      if (out_valid !== 1'b1 || out_result !== t_r[i]) begin
        errors++;
        $display("FAIL single_cycle_%0d: valid=%b res=%h, required valid=1 res=%h",
                 i, out_valid, out_result, t_r[i]);
      end
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [4:0] ops[4];
    ops = '{5'd18, 5'd25, 5'd31, 5'd10};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 32'h55AA55AA, 32'h3, model(ops[i], 32'h55AA55AA, 32'h3), 1'b1);
      if (ops[i] != 5'd10 || !MD) begin
        checks = checks + 1;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== '0) begin
          errors++;
          $display("FAIL illegal_op_%0d: valid=%b ill=%b res=%h, required 1 1 0",
                   ops[i], out_valid, out_illegal, out_result);
        end
      end
    end
    repeat (MD ? WIDTH + 3 : 2) tick();
  endtask

  task automatic test_hold();
    int bad = 0;
    out_ready = 1'b0;
    send(5'd0, 32'h1230, 32'h4, {1'b0, 32'h1234}, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== 32'h1234 || in_ready !== 1'b0) bad++;
      tick();
    end
    checks = checks + 1;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: bad cycles=%0d, required 0", bad);
    end
    out_ready = 1'b1;
    tick();
    checks = checks + 1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_retire: valid=%b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int start;
    int gaps = 0;
    logic [WIDTH-1:0] a, b;
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = $urandom();
      send(5'd0, a, b, model(5'd0, a, b), 1'b1);
      if (out_valid !== 1'b1) gaps++;
    end
    checks = checks + 2;
    if (cyc - start !== 8) begin errors++; $display("FAIL b2b_cycles: got %0d, required 8", cyc - start); end
    if (gaps !== 0) begin errors++; $display("FAIL b2b_valid: gaps=%0d, required 0", gaps); end
    tick();
  endtask

  task automatic test_muldiv();
    int n = 0;
    int busy_bad = 0;
    logic [4:0] t_op[9];
    logic [WIDTH-1:0] t_a[9], t_b[9];
    logic [WIDTH-1:0] a, b;
    logic [4:0] op;
    out_ready = 1'b1;
    send(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? {1'b0, 32'hFFFFFFFE} : {1'b1, 32'h0}, 1'b1);
    while (!out_valid && n < 100) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    checks = checks + 3;
    if (n !== (MD ? WIDTH + 1 : 0)) begin
      errors++;
      $display("FAIL mulhu_latency: edges=%0d, required %0d", n, MD ? WIDTH + 1 : 0);
    end
    if (busy_bad !== 0) begin errors++; $display("FAIL busy_iterating: low cycles=%0d, required 0", busy_bad); end
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b, required 0", busy); end
    send(5'd14, 32'h80000000, 32'hFFFFFFFF, MD ? {1'b0, 32'h80000000} : {1'b1, 32'h0}, 1'b1);
    send(5'd15, 32'h7, 32'h0, MD ? {1'b0, 32'hFFFFFFFF} : {1'b1, 32'h0}, 1'b1);
    send(5'd16, 32'h7, 32'h0, MD ? {1'b0, 32'h7} : {1'b1, 32'h0}, 1'b1);
    t_op = '{5'd10, 5'd11, 5'd12, 5'd14, 5'd16, 5'd16, 5'd17, 5'd14, 5'd15};
    t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'h80000000, 32'h7, 32'hFFFFFFF9, 32'hDEADBEEF};
    t_b  = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h10};
    for (int i = 0; i < 9; i++) send(t_op[i], t_a[i], t_b[i], model(t_op[i], t_a[i], t_b[i]), 1'b1);
    for (int i = 0; i < 8; i++) begin
      op = 5'($urandom_range(10, 17));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      send(op, a, b, model(op, a, b), 1'b1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(5'd14, 32'd100, 32'd7, '0, 1'b0);
    repeat (10) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = 32'd9;
    in_b     = 32'd9;
    #1;
    checks = checks + 1;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    watch_idle("flush_discard", 40);
    send(5'd0, 32'd2, 32'd3, {1'b0, 32'd5}, 1'b1);
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_result !== 32'd5) begin
      errors++;
      $display("FAIL flush_next_add: valid=%b res=%h, required 1 5", out_valid, out_result);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    send(5'd10, 32'd1234, 32'd5678, '0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks = checks + 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b, required 0", busy); end
    if (out_result !== '0) begin errors++; $display("FAIL rst_async_result: got %h, required 0", out_result); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    watch_idle("rst_discard", 40);
    send(5'd0, 32'd2, 32'd3, {1'b0, 32'd5}, 1'b1);
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_result !== 32'd5) begin
      errors++;
      $display("FAIL rst_next_add: valid=%b res=%h, required 1 5", out_valid, out_result);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [WIDTH-1:0] a, b;
    int n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom();
      b  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom();
      send(op, a, b, model(op, a, b), 1'b1);
    end
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_muldiv();
    test_flush();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
